iq_discriminator: RTL
=====================

Name: iq_discriminator

Overview:
- Downstream consumer of the integrator's iq_valid/i_val/q_val stream.
- Classifies each integrated IQ shot as excited or ground against the configured decision line (i_pt_line/q_pt_line point, i_vec_perp/q_vec_perp normal vector).
- Emits a per-shot state bit and, in accumulate mode, counts excited and ground shots over num_data_pts shots, then presents the totals under a valid/ready handshake.

Parameters:
- DATA_W, 32, width of signed i_val/q_val, vec_perp and pt_line inputs.
- CNT_W, 16, width of num_data_pts and the shot counters.
- SUM_W, 48, width of the optional IQ sum accumulators.

Ports:
- clk100  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle arm pulse for an accumulate run.
- iq_valid  in  1  integrated shot available this cycle.
- i_val, q_val  in  DATA_W  signed integrated I and Q.
- i_vec_perp, q_vec_perp  in  DATA_W  signed normal to the decision line.
- i_pt_line, q_pt_line  in  DATA_W  signed point on the decision line.
- analyze_mode  in  2  2'b01 = accumulate; any other value = per-shot only.
- num_data_pts  in  CNT_W  shots per run.
- state_valid  out  1  per-shot classification valid.
- state_bit  out  1  1 = excited, 0 = ground.
- busy  out  1  FSM is in ACCUM.
- result_valid  out  1  run totals valid.
- result_ready  in  1  consumer accepts the totals.
- excited_count, ground_count  out  CNT_W  run totals.
- i_sum, q_sum  out  SUM_W  signed sums (present only with the macro defined).

Behaviour:
- Reset: all outputs 0 and all pipeline valids cleared. FSM goes to IDLE. Reset mid-run abandons the run with no result.
- Projection: d = (i_val-i_pt_line)*i_vec_perp + (q_val-q_pt_line)*q_vec_perp.
  - Differences are 33-bit signed, products 66-bit signed, sum 67-bit signed. All full precision; nothing is truncated or saturated.
  - Excited iff d > 0. d == 0 is classified as ground.
- Latency: a 3-stage pipeline (subtract, multiply, add/compare). state_valid/state_bit are asserted exactly 3 cycles after the iq_valid cycle, with throughput of 1 shot per cycle.
- Per-shot outputs run in every FSM state and every mode.
- Config inputs are sampled with the shot in stage 1. They are assumed static during a run.
- FSM IDLE:
  - start with analyze_mode==2'b01: latch num_data_pts as target, clear counters (and sums), go to ACCUM.
  - start with any other mode is ignored.
- FSM ACCUM (busy=1):
  - Each state_valid increments excited_count or ground_count.
  - When excited+ground reaches target (counting the current shot), go to DONE and assert result_valid the next cycle.
  - target==0: go to DONE on the cycle after start, with zero totals.
  - start while in ACCUM is ignored.
- FSM DONE:
  - result_valid=1 and the totals are held stable.
  - state_valid shots arriving in DONE are not counted.
  - result_valid && result_ready: go to IDLE and drop result_valid the next cycle. The totals stay readable until the next start.
  - start in DONE is ignored until the handshake completes.
- Boundary cases:
  - A shot whose state_valid coincides with the start cycle is not counted.
  - Shots already in the pipeline at start are counted if their state_valid falls in ACCUM.
  - Counters cannot wrap, because the total is bounded by target ≤ 2^CNT_W-1.

Optional Feature:
- Macro IQ_DISC_SUM_EN.
- When defined: i_sum and q_sum ports exist. They accumulate the sign-extended i_val/q_val of each counted shot, are cleared at start, are held in DONE, and reset to 0.
- When undefined: the ports, accumulators and stage-1 IQ delay registers are all absent. Everything else is unchanged.

Decomposition:
- Package iq_disc_pkg holds:
  - the FSM enum: IDLE, ACCUM, DONE;
  - the constants DIFF_W=33, PROD_W=66, PROJ_W=67;
  - the mode constant MODE_ACCUM=2'b01.
- Sub-module iq_disc_proj implements the 3-stage projection pipeline (valid in → valid + state_bit out). The top module holds the FSM, counters and optional sums.

Test Plan:
- Boundary classification: perp=(1,0), pt=(0,0); shots i=5, 0, -5 with q=0 → state_bit 1, 0, 0, each state_valid 3 cycles after its iq_valid.
- Full-range operands: i_val=32'h7FFFFFFF, i_pt_line=32'h80000000, i_vec_perp=32'h80000000, q terms 0 → d=-(2^32-1)*2^31 <0, so state_bit=0 with no overflow.
- Back-to-back run: mode 01, num_data_pts=4, start, then 4 consecutive shots (3 excited, 1 ground) → result_valid asserted, excited=3, ground=1. result_ready held 0 for 5 cycles → totals stable; extra shots in DONE are not counted.
- Zero-length and mode gating:
  - num_data_pts=0 → result_valid the cycle after start, counts 0/0.
  - mode 00 + start → busy stays 0, while per-shot outputs still toggle.
- Reset mid-run: after 2 of 10 shots, pulse reset → all outputs 0 and FSM in IDLE. A new start+10 shots then yields correct totals.
- IQ_DISC_SUM_EN defined, 3 shots (i,q)=(100,-4),(-50,2),(7,7) → i_sum=57, q_sum=5 at result_valid.

Source files
------------

// File: rtl/iq_disc_pkg.sv
// Shared types and fixed widths for the IQ state discriminator.
// IQ_DISC_SUM_EN (when defined) adds the IQ sum accumulators to the design.
package iq_disc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } disc_state_t;

   localparam int DIFF_W = 33;
   localparam int PROD_W = 66;
   localparam int PROJ_W = 67;

   localparam logic [1:0] MODE_ACCUM = 2'b01;

endpackage

// File: rtl/iq_discriminator_if.sv
// Shot stream in, per-shot state and run totals out; macro IQ_DISC_SUM_EN adds i_sum/q_sum.
interface iq_discriminator_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
`ifdef IQ_DISC_SUM_EN
   ,
   parameter int SUM_W  = 48
`endif
);

   logic                     iq_valid;
   logic signed [DATA_W-1:0] i_val;
   logic signed [DATA_W-1:0] q_val;
   logic                     state_valid;
   logic                     state_bit;
   logic                     result_valid;
   logic                     result_ready;
   logic [CNT_W-1:0]         excited_count;
   logic [CNT_W-1:0]         ground_count;
`ifdef IQ_DISC_SUM_EN
   logic signed [SUM_W-1:0]  i_sum;
   logic signed [SUM_W-1:0]  q_sum;

   modport master (
      output iq_valid, i_val, q_val, result_ready,
      input  state_valid, state_bit, result_valid, excited_count, ground_count, i_sum, q_sum
   );

   modport slave (
      input  iq_valid, i_val, q_val, result_ready,
      output state_valid, state_bit, result_valid, excited_count, ground_count, i_sum, q_sum
   );
`else
   modport master (
      output iq_valid, i_val, q_val, result_ready,
      input  state_valid, state_bit, result_valid, excited_count, ground_count
   );

   modport slave (
      input  iq_valid, i_val, q_val, result_ready,
      output state_valid, state_bit, result_valid, excited_count, ground_count
   );
`endif

endinterface

// File: rtl/iq_disc_proj.sv
// Three-stage projection of an IQ shot onto the decision-line normal.
// Everything is kept at full precision, so the sign of the projection is exact.
module iq_disc_proj
   import iq_disc_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     vld_in,
   input  logic signed [DATA_W-1:0] i_val,
   input  logic signed [DATA_W-1:0] q_val,
   input  logic signed [DATA_W-1:0] i_vec_perp,
   input  logic signed [DATA_W-1:0] q_vec_perp,
   input  logic signed [DATA_W-1:0] i_pt_line,
   input  logic signed [DATA_W-1:0] q_pt_line,
   output logic                     vld_out,
   output logic                     state_bit
);

   logic                     vld_p0, vld_p1;
   logic signed [DIFF_W-1:0] di_p0, dq_p0, vi_p0, vq_p0;
   logic signed [PROD_W-1:0] pi_p1, pq_p1;
   logic signed [PROJ_W-1:0] proj_p1;

   function automatic logic signed [DIFF_W-1:0] sext_diff(input logic signed [DATA_W-1:0] x);
      return {{(DIFF_W-DATA_W){x[DATA_W-1]}}, x};
   endfunction

   function automatic logic signed [PROD_W-1:0] full_mul(input logic signed [DIFF_W-1:0] a,
                                                         input logic signed [DIFF_W-1:0] b);
      logic signed [PROD_W-1:0] a_w, b_w;
      a_w = {{(PROD_W-DIFF_W){a[DIFF_W-1]}}, a};
      b_w = {{(PROD_W-DIFF_W){b[DIFF_W-1]}}, b};
      return a_w * b_w;
   endfunction

   always_ff @(posedge clk) begin
      // stage 1: offset from the line point, config captured with the shot
      di_p0 <= sext_diff(i_val) - sext_diff(i_pt_line);
      dq_p0 <= sext_diff(q_val) - sext_diff(q_pt_line);
      vi_p0 <= sext_diff(i_vec_perp);
      vq_p0 <= sext_diff(q_vec_perp);
      // stage 2: multiply by the normal
      pi_p1 <= full_mul(di_p0, vi_p0);
      pq_p1 <= full_mul(dq_p0, vq_p0);
   end

   assign proj_p1 = {pi_p1[PROD_W-1], pi_p1} + {pq_p1[PROD_W-1], pq_p1};

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0    <= 1'b0;
         vld_p1    <= 1'b0;
         vld_out   <= 1'b0;
         state_bit <= 1'b0;
      end else begin
         vld_p0    <= vld_in;
         vld_p1    <= vld_p0;
         // stage 3: strictly positive projection means excited; zero is ground
         vld_out   <= vld_p1;
         state_bit <= vld_p1 && !proj_p1[PROJ_W-1] && (proj_p1 != '0);
      end
   end

endmodule

// File: rtl/iq_discriminator.sv
// IQ discriminator top: projection pipeline plus accumulate-mode run FSM.
// Defining IQ_DISC_SUM_EN adds signed i_sum/q_sum accumulators over counted shots.
module iq_discriminator
   import iq_disc_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 16
`ifdef IQ_DISC_SUM_EN
   ,
   parameter int SUM_W  = 48
`endif
) (
   input  logic                     clk100,
   input  logic                     reset,
   input  logic                     start,
   input  logic signed [DATA_W-1:0] i_vec_perp,
   input  logic signed [DATA_W-1:0] q_vec_perp,
   input  logic signed [DATA_W-1:0] i_pt_line,
   input  logic signed [DATA_W-1:0] q_pt_line,
   input  logic [1:0]               analyze_mode,
   input  logic [CNT_W-1:0]         num_data_pts,
   output logic                     busy,
   iq_discriminator_if.slave        bus
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   disc_state_t      state;
   logic [CNT_W-1:0] target, exc_cnt, gnd_cnt;
   logic             res_vld;
   logic             shot_vld, shot_bit;
   logic [CNT_W:0]   seen_next;
   logic             target_hit;

   iq_disc_proj #(.DATA_W(DATA_W)) u_proj (
      .clk        (clk100),
      .rst        (reset),
      .vld_in     (bus.iq_valid),
      .i_val      (bus.i_val),
      .q_val      (bus.q_val),
      .i_vec_perp (i_vec_perp),
      .q_vec_perp (q_vec_perp),
      .i_pt_line  (i_pt_line),
      .q_pt_line  (q_pt_line),
      .vld_out    (shot_vld),
      .state_bit  (shot_bit)
   );

   // One extra bit so target = 2^CNT_W-1 is reachable without wrap.
   assign seen_next  = {1'b0, exc_cnt} + {1'b0, gnd_cnt} + {{CNT_W{1'b0}}, 1'b1};
   assign target_hit = (seen_next == {1'b0, target});

`ifdef IQ_DISC_SUM_EN
   logic signed [DATA_W-1:0] i_p0, i_p1, i_p2, q_p0, q_p1, q_p2;
   logic signed [SUM_W-1:0]  i_acc, q_acc;

   function automatic logic signed [SUM_W-1:0] sext_sum(input logic signed [DATA_W-1:0] x);
      return {{(SUM_W-DATA_W){x[DATA_W-1]}}, x};
   endfunction

   // IQ delay line kept in step with the projection so sums pair with state_valid
   always_ff @(posedge clk100) begin
      i_p0 <= bus.i_val;
      q_p0 <= bus.q_val;
      i_p1 <= i_p0;
      q_p1 <= q_p0;
      i_p2 <= i_p1;
      q_p2 <= q_p1;
   end

   assign bus.i_sum = i_acc;
   assign bus.q_sum = q_acc;
`endif

   always_ff @(posedge clk100) begin
      if (reset) begin
         state   <= IDLE;
         busy    <= 1'b0;
         res_vld <= 1'b0;
         target  <= '0;
         exc_cnt <= '0;
         gnd_cnt <= '0;
`ifdef IQ_DISC_SUM_EN
         i_acc   <= '0;
         q_acc   <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start && analyze_mode == MODE_ACCUM) begin
                  target  <= num_data_pts;
                  exc_cnt <= '0;
                  gnd_cnt <= '0;
`ifdef IQ_DISC_SUM_EN
                  i_acc   <= '0;
                  q_acc   <= '0;
`endif
                  if (num_data_pts == '0) begin
                     state   <= DONE;
                     res_vld <= 1'b1;
                  end else begin
                     state <= ACCUM;
                     busy  <= 1'b1;
                  end
               end
            end
            ACCUM: begin
               if (shot_vld) begin
                  if (shot_bit) exc_cnt <= exc_cnt + CNT_ONE;
                  else          gnd_cnt <= gnd_cnt + CNT_ONE;
`ifdef IQ_DISC_SUM_EN
                  i_acc <= i_acc + sext_sum(i_p2);
                  q_acc <= q_acc + sext_sum(q_p2);
`endif
                  if (target_hit) begin
                     state   <= DONE;
                     busy    <= 1'b0;
                     res_vld <= 1'b1;
                  end
               end
            end
            DONE: begin
               if (bus.result_ready) begin
                  state   <= IDLE;
                  res_vld <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               res_vld <= 1'b0;
            end
         endcase
      end
   end

   assign bus.state_valid   = shot_vld;
   assign bus.state_bit     = shot_bit;
   assign bus.result_valid  = res_vld;
   assign bus.excited_count = exc_cnt;
   assign bus.ground_count  = gnd_cnt;

endmodule
